mtimer_clint: RTL and testbench
===============================

# mtimer_clint

Parametrised machine-timer and software-interrupt unit (CLINT-style) for one or more harts, replacing the single fixed mtime/mtimecmp pair. Sits on the data-memory bus at the timer window and holds a 64-bit free-running mtime with a programmable prescaler, per-hart 64-bit mtimecmp and msip registers, and a tear-free 64-bit read path. Drives the per-hart mip.MTIP and mip.MSIP inputs of the CSR file.

## Interface
- NUM_HARTS, 1: number of mtimecmp/msip channels, 1..8
- BASE_ADDR, 32'h0000_8000: base of the 512-byte register window
- PRESC_WIDTH, 8: prescaler register width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bus_req  in  1  access request, sampled on each rising edge
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  32  byte address; word accesses only, bits [1:0] ignored
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid while bus_ready = 1
- bus_ready  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle pulse with bus_ready for an unmapped address
- timer_irq  out  NUM_HARTS  per-hart MTIP
- soft_irq  out  NUM_HARTS  per-hart MSIP

## Operation
- Register map (offset from BASE_ADDR):
  - 0x000 PRESC: bits [PRESC_WIDTH-1:0] RW, upper bits read 0
  - 0x004 MTIME_LO, 0x008 MTIME_HI
  - 0x00C+8h MTIMECMP_LO[h], 0x010+8h MTIMECMP_HI[h], h = 0..NUM_HARTS-1
  - 0x100+4h MSIP[h]: bit 0 RW, upper bits read 0
  - For NUM_HARTS = 1 the offsets match the existing MTIME/MTIMECMP addresses 0x8004..0x8010.
- Any other offset, and any offset for a hart index >= NUM_HARTS, is unmapped: reads return 0, writes are ignored, and bus_err pulses.
- Prescaler: a counter pcnt counts 0..PRESC. mtime increments by 1 on the cycle pcnt == PRESC, and pcnt then returns to 0. PRESC = 0 means increment every cycle.
- A write to PRESC clears pcnt.
- mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to MTIME_LO or MTIME_HI replaces that half and suppresses the increment in that cycle. The other half is unchanged; there is no carry.
- Tear-free read: reading MTIME_LO returns mtime[31:0] and latches mtime[63:32] into a shadow register. Reading MTIME_HI returns the shadow. Software must read LO and then HI.
- The shadow is also loaded by any write to MTIME_HI (with the written value) or MTIME_LO (with current mtime[63:32]).
- timer_irq[h] is a register, updated every cycle with (mtime >= mtimecmp[h]) using the current register values. The comparison is unsigned 64-bit.
- soft_irq[h] = MSIP[h] bit 0, registered.
- Reset values:
  - mtime = 0, pcnt = 0, PRESC = 0, shadow = 0
  - mtimecmp[h] = all ones, MSIP = 0
  - timer_irq = 0, soft_irq = 0
  - bus_rdata = 0, bus_ready = 0, bus_err = 0
- Reset asserted mid-operation returns all state to these values immediately. Any in-flight response is dropped: bus_ready does not pulse for it.

## Timing
- Fully pipelined with fixed 1-cycle latency. A request sampled at edge N gives bus_ready (plus bus_rdata/bus_err) high during cycle N+1. A new request may be presented every cycle.
- A write commits at the sampling edge N. A read sampled at edge N+1 of the same register returns the new value.
- Read data reflects register state before edge N. A read of MTIME_LO coinciding with an increment returns the pre-increment value, and the shadow pairs with it.
- timer_irq latency:
  - mtime reaching mtimecmp at edge N gives timer_irq high after edge N+1.
  - A write to mtimecmp raising it above mtime at edge N gives timer_irq low after edge N+1.
- soft_irq follows an MSIP write one edge later (high from N+1).
- An mtime write and a would-be increment in the same cycle: the write wins and no increment is lost or added later. pcnt still advances or wraps normally.

## Test plan
- Reset, then idle 10 cycles with PRESC = 0 → MTIME_LO reads 10±1. timer_irq stays 0 because mtimecmp is all ones. Read of 0x8010 returns 0xFFFF_FFFF.
- Write PRESC = 3 and wait 40 cycles → mtime advances exactly 10. Rewrite PRESC mid-count → next increment occurs PRESC+1 cycles after the write.
- Write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, then read LO, HI across the carry → the pair is consistent (0xFFFF_FFFE/0 or 0xFFFF_FFFF/0, never 0/0). The next LO/HI pair reads 0x0000_000x/1.
- Write mtimecmp[0] = mtime+5 → timer_irq[0] rises exactly 1 cycle after mtime == cmp. Write cmp = 0xFFFF_FFFF_FFFF_FFFF → timer_irq[0] falls 1 cycle later.
- NUM_HARTS = 4: write MSIP[2] = 1 → only soft_irq[2] high. Write mtimecmp[3] = 0 → only timer_irq[3] high.
- Read 0x8050 (unmapped for 4 harts) and 0x8200 → rdata 0 with bus_err pulse. A write there leaves all registers unchanged. Assert rst for 1 cycle mid-sequence → all outputs return to reset values and no pending bus_ready pulse appears.

Source files
------------

// File: rtl/mtimer_clint.sv
// -----------------------------------------------------------------------------
// mtimer_clint
//
// CLINT-style machine timer and software-interrupt unit for NUM_HARTS harts.
// It holds a free-running 64-bit mtime advanced through a programmable
// prescaler. Each hart has a 64-bit mtimecmp and an msip bit. MTIME reads are
// tear-free: reading MTIME_LO latches the matching upper half into a shadow
// register, and MTIME_HI returns that shadow. Every bus access completes with
// a fixed one-cycle latency.
//
// Register map (byte offsets from BASE_ADDR, word accesses only):
//   0x000        PRESC          [PRESC_WIDTH-1:0] RW
//   0x004        MTIME_LO
//   0x008        MTIME_HI       (reads return the shadow)
//   0x00C+8h     MTIMECMP_LO[h]
//   0x010+8h     MTIMECMP_HI[h]
//   0x100+4h     MSIP[h]        bit 0 RW
//   Any other offset is unmapped: reads return 0, writes are dropped, and
//   bus_err pulses together with bus_ready.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   bus_req      request, sampled on each rising edge
//   bus_we       1 = write, 0 = read
//   bus_addr     byte address (bits [1:0] ignored)
//   bus_wdata    write data
//   bus_rdata    read data, valid while bus_ready is high
//   bus_ready    one-cycle completion pulse, one cycle after the request
//   bus_err      pulses with bus_ready for an unmapped address
//   timer_irq    per-hart MTIP (registered)
//   soft_irq     per-hart MSIP (registered)
// -----------------------------------------------------------------------------
module mtimer_clint #(
  parameter int unsigned NUM_HARTS   = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_req,
  input  logic                 bus_we,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  output logic                 bus_err,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRESC,
    SEL_MT_LO,
    SEL_MT_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MSIP
  } sel_e;

  // Word-index bounds of the per-hart register groups.
  localparam logic [6:0] CMP_W_BASE  = 7'd3;
  localparam logic [6:0] CMP_W_END   = 7'(3 + 2 * NUM_HARTS);
  localparam logic [6:0] MSIP_W_BASE = 7'd64;
  localparam logic [6:0] MSIP_W_END  = 7'(64 + NUM_HARTS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0]            mtime_q,   mtime_d;
  logic [PRESC_WIDTH-1:0] pcnt_q,    pcnt_d;
  logic [PRESC_WIDTH-1:0] presc_q,   presc_d;
  logic [31:0]            shadow_q,  shadow_d;
  logic [63:0]            mtimecmp_q [NUM_HARTS];
  logic [63:0]            mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0]   msip_q,    msip_d;
  logic [NUM_HARTS-1:0]   timer_irq_q, timer_irq_d;
  logic [NUM_HARTS-1:0]   soft_irq_q,  soft_irq_d;
  logic [31:0]            bus_rdata_q, bus_rdata_d;
  logic                   bus_ready_q, bus_ready_d;
  logic                   bus_err_q,   bus_err_d;

  // ---------------------------------------------------------------------------
  // Address decode (word granularity; the window is 128 words)
  // ---------------------------------------------------------------------------
  logic [29:0] word;
  logic [6:0]  widx;
  logic [6:0]  rel_cmp;
  logic [6:0]  rel_msip;
  sel_e        sel;
  logic [2:0]  sel_h;
  logic        wr;
  logic        rd;
  logic        unused_bits;

  assign word     = bus_addr[31:2] - BASE_ADDR[31:2];
  assign widx     = word[6:0];
  assign rel_cmp  = widx - CMP_W_BASE;
  assign rel_msip = widx - MSIP_W_BASE;
  assign wr       = bus_req &  bus_we;
  assign rd       = bus_req & ~bus_we;

  assign unused_bits = ^{bus_addr[1:0], rel_cmp[6:4], rel_msip[6:3]};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel   = SEL_NONE;
    sel_h = '0;
    if (word[29:7] == '0) begin
      if (widx == 7'd0) begin
        sel = SEL_PRESC;
      end else if (widx == 7'd1) begin
        sel = SEL_MT_LO;
      end else if (widx == 7'd2) begin
        sel = SEL_MT_HI;
      end else if (widx >= CMP_W_BASE && widx < CMP_W_END) begin
        // Two words per hart: rel_cmp[0] selects the high half.
        sel_h = rel_cmp[3:1];
        sel   = rel_cmp[0] ? SEL_CMP_HI : SEL_CMP_LO;
      end else if (widx >= MSIP_W_BASE && widx < MSIP_W_END) begin
        sel_h = rel_msip[2:0];
        sel   = SEL_MSIP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: register state as it was before the sampling edge
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (sel)
      SEL_PRESC: rd_data = 32'(presc_q);
      SEL_MT_LO: rd_data = mtime_q[31:0];
      SEL_MT_HI: rd_data = shadow_q;
      SEL_CMP_LO, SEL_CMP_HI, SEL_MSIP: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (sel_h == 3'(h)) begin
            if (sel == SEL_CMP_LO)      rd_data = mtimecmp_q[h][31:0];
            else if (sel == SEL_CMP_HI) rd_data = mtimecmp_q[h][63:32];
            else                        rd_data = {31'b0, msip_q[h]};
          end
        end
      end
      default: rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic tick;

  assign tick = (pcnt_q == presc_q);

  always_comb begin
    presc_d    = presc_q;
    pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    shadow_d   = shadow_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    if (wr && sel == SEL_PRESC) begin
      presc_d = bus_wdata[PRESC_WIDTH-1:0];
      pcnt_d  = '0;
    end

    // An mtime write replaces one half and takes the place of any increment
    // due this cycle; the other half is kept with no carry. pcnt is unaffected.
    if (wr && sel == SEL_MT_LO) begin
      mtime_d  = {mtime_q[63:32], bus_wdata};
      shadow_d = mtime_q[63:32];
    end
    if (wr && sel == SEL_MT_HI) begin
      mtime_d  = {bus_wdata, mtime_q[31:0]};
      shadow_d = bus_wdata;
    end
    // The shadow pairs with the pre-increment LO value returned by this read.
    if (rd && sel == SEL_MT_LO) begin
      shadow_d = mtime_q[63:32];
    end

    for (int h = 0; h < NUM_HARTS; h++) begin
      if (wr && sel_h == 3'(h)) begin
        if (sel == SEL_CMP_LO) mtimecmp_d[h][31:0]  = bus_wdata;
        if (sel == SEL_CMP_HI) mtimecmp_d[h][63:32] = bus_wdata;
        if (sel == SEL_MSIP)   msip_d[h]            = bus_wdata[0];
      end
      timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end

    soft_irq_d  = msip_q;
    bus_ready_d = bus_req;
    bus_err_d   = bus_req && (sel == SEL_NONE);
    bus_rdata_d = rd ? rd_data : '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      pcnt_q      <= '0;
      presc_q     <= '0;
      shadow_q    <= '0;
      // NOTE: the mtimecmp array is architectural state with a defined reset
      // value, so it is built from resettable flops rather than a RAM.
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
      msip_q      <= '0;
      timer_irq_q <= '0;
      soft_irq_q  <= '0;
      bus_rdata_q <= '0;
      bus_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      pcnt_q      <= pcnt_d;
      presc_q     <= presc_d;
      shadow_q    <= shadow_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      soft_irq_q  <= soft_irq_d;
      bus_rdata_q <= bus_rdata_d;
      bus_ready_q <= bus_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign bus_ready = bus_ready_q;
  assign bus_err   = bus_err_q;
  assign timer_irq = timer_irq_q;
  assign soft_irq  = soft_irq_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// -----------------------------------------------------------------------------
// tb_mtimer_clint
//
// Self-checking bench for mtimer_clint with four harts. Bus stimulus is driven
// on falling edges; each issued access pushes its expected response into a
// scoreboard queue, and a monitor pops and compares whenever bus_ready is seen
// on a falling edge. Interrupt outputs are checked directly at chosen cycles.
// -----------------------------------------------------------------------------
module tb_mtimer_clint;

  localparam int unsigned NH = 4;

  localparam logic [31:0] A_PRESC = 32'h0000_8000;
  localparam logic [31:0] A_MT_LO = 32'h0000_8004;
  localparam logic [31:0] A_MT_HI = 32'h0000_8008;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_req = 1'b0;
  logic          bus_we = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_ready;
  logic          bus_err;
  logic [NH-1:0] timer_irq;
  logic [NH-1:0] soft_irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] lo;   // accepted rdata range [lo, hi]
    logic [31:0] hi;
    logic        err;
    logic        chk;  // compare rdata (reads only)
  } exp_t;

  exp_t sb[$];

  mtimer_clint #(
    .NUM_HARTS  (NH),
    .BASE_ADDR  (32'h0000_8000),
    .PRESC_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .bus_err  (bus_err),
    .timer_irq(timer_irq),
    .soft_irq (soft_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [31:0] lo,
                        input logic [31:0] hi, input logic err, input string name);
    exp_t e;
    @(negedge clk);
    bus_req   = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = addr;
    bus_wdata = '0;
    e.name = name; e.lo = lo; e.hi = hi; e.err = err; e.chk = 1'b1;
    sb.push_back(e);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic err, input string name);
    exp_t e;
    @(negedge clk);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    e.name = name; e.lo = '0; e.hi = '0; e.err = err; e.chk = 1'b0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_req = 1'b0;
      bus_we  = 1'b0;
    end
  endtask

  function automatic logic [31:0] cmp_lo(input int h);
    return 32'h0000_800C + 32'(8 * h);
  endfunction

  function automatic logic [31:0] msip_a(input int h);
    return 32'h0000_8100 + 32'(4 * h);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_err && !bus_ready) begin
          total++;
          bad++;
          $display("FAIL err_without_ready: bus_err=1 while bus_ready=0");
        end
        if (bus_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready: rdata=%h err=%b with no request pending",
                     bus_rdata, bus_err);
          end else begin
            e = sb.pop_front();
            if (bus_err !== e.err ||
                (e.chk && (bus_rdata < e.lo || bus_rdata > e.hi))) begin
              bad++;
              $display("FAIL %s: got rdata=%h err=%b want rdata=%h..%h err=%b",
                       e.name, bus_rdata, bus_err, e.lo, e.hi, e.err);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state while rst is held.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_ready), 32'd0);
    check("rst_err",   32'(bus_err),   32'd0);
    check("rst_rdata", bus_rdata,      32'd0);
    check("rst_tirq",  32'(timer_irq), 32'd0);
    check("rst_sirq",  32'(soft_irq),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with PRESC = 0: read sampled on the 11th edge returns 10.
    idle(9);
    bus_rd(A_MT_LO, 32'd9, 32'd11, 1'b0, "idle_mtime_lo");
    bus_rd(A_MT_HI, 32'd0, 32'd0, 1'b0, "idle_mtime_hi");
    bus_rd(32'h0000_8010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "cmp0_hi_reset");
    idle(1);
    check("idle_tirq", 32'(timer_irq), 32'd0);

    // Prescaler = 3: ten increments over forty cycles.
    bus_wr(A_MT_HI, 32'd0,   1'b0, "wr_mt_hi");
    bus_wr(A_MT_LO, 32'd100, 1'b0, "wr_mt_lo");
    bus_wr(A_PRESC, 32'd3,   1'b0, "wr_presc3");            // edge S, +1 with old PRESC
    bus_rd(A_MT_LO, 32'd101, 32'd101, 1'b0, "presc3_start");
    idle(39);
    bus_rd(A_MT_LO, 32'd111, 32'd111, 1'b0, "presc3_plus10");
    // Rewrite mid-count: next increment PRESC+1 = 6 edges after the write.
    bus_wr(A_PRESC, 32'd5, 1'b0, "wr_presc5");
    idle(4);
    bus_rd(A_MT_LO, 32'd111, 32'd111, 1'b0, "presc5_hold_a");
    bus_rd(A_MT_LO, 32'd111, 32'd111, 1'b0, "presc5_hold_b");
    bus_rd(A_MT_LO, 32'd112, 32'd112, 1'b0, "presc5_step");
    bus_wr(A_PRESC, 32'd0, 1'b0, "wr_presc0");

    // Tear-free read across the 32-bit carry.
    bus_wr(A_MT_HI, 32'd0,          1'b0, "carry_wr_hi");
    bus_wr(A_MT_LO, 32'hFFFF_FFFE,  1'b0, "carry_wr_lo");
    bus_rd(A_MT_LO, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, "carry_lo_a");
    idle(1);                                                 // carry happens here
    bus_rd(A_MT_HI, 32'd0, 32'd0, 1'b0, "carry_hi_a");
    bus_rd(A_MT_LO, 32'd1, 32'd1, 1'b0, "carry_lo_b");
    bus_rd(A_MT_HI, 32'd1, 32'd1, 1'b0, "carry_hi_b");

    // timer_irq[0]: mtime = 0 after U1, cmp = 10; mtime hits 10 at U11.
    bus_wr(A_MT_HI, 32'd0, 1'b0, "tm_wr_hi");
    bus_wr(A_MT_LO, 32'd0, 1'b0, "tm_wr_lo");
    bus_wr(cmp_lo(0) + 32'd4, 32'd0,  1'b0, "tm_cmp_hi");
    bus_wr(cmp_lo(0),         32'd10, 1'b0, "tm_cmp_lo");
    idle(9);
    check("tirq_at_match", 32'(timer_irq), 32'b0000);
    idle(1);
    check("tirq_after_match", 32'(timer_irq), 32'b0001);
    bus_wr(cmp_lo(0) + 32'd4, 32'hFFFF_FFFF, 1'b0, "tm_cmp_hi_max");
    idle(1);
    check("tirq_cmp_wr_edge", 32'(timer_irq), 32'b0001);
    idle(1);
    check("tirq_cmp_raised", 32'(timer_irq), 32'b0000);
    bus_wr(cmp_lo(0), 32'hFFFF_FFFF, 1'b0, "tm_cmp_lo_max");

    // Software interrupt on hart 2 and timer on hart 3.
    bus_wr(msip_a(2), 32'd1, 1'b0, "wr_msip2");
    idle(1);
    check("sirq_write_edge", 32'(soft_irq), 32'b0000);
    idle(1);
    check("sirq_hart2", 32'(soft_irq), 32'b0100);
    bus_rd(msip_a(2), 32'd1, 32'd1, 1'b0, "rd_msip2");
    bus_wr(msip_a(1), 32'hFFFF_FFFE, 1'b0, "wr_msip1_bit0_clear");
    bus_rd(msip_a(1), 32'd0, 32'd0, 1'b0, "rd_msip1");
    bus_wr(cmp_lo(3),         32'd0, 1'b0, "wr_cmp3_lo");
    bus_wr(cmp_lo(3) + 32'd4, 32'd0, 1'b0, "wr_cmp3_hi");
    idle(1);
    check("tirq3_write_edge", 32'(timer_irq), 32'b0000);
    idle(1);
    check("tirq_hart3", 32'(timer_irq), 32'b1000);
    bus_wr(A_PRESC, 32'h1234_5602, 1'b0, "wr_presc_wide");
    bus_rd(A_PRESC, 32'd2, 32'd2, 1'b0, "rd_presc_masked");
    bus_wr(A_PRESC, 32'd0, 1'b0, "wr_presc_zero");

    // Unmapped window accesses.
    bus_rd(32'h0000_8050, 32'd0, 32'd0, 1'b1, "rd_unmapped_8050");
    bus_rd(32'h0000_8200, 32'd0, 32'd0, 1'b1, "rd_unmapped_8200");
    bus_rd(32'h0000_802C, 32'd0, 32'd0, 1'b1, "rd_unmapped_cmp4");
    bus_rd(32'h0000_7FFC, 32'd0, 32'd0, 1'b1, "rd_below_base");
    bus_wr(32'h0000_8050, 32'hFFFF_FFFF, 1'b1, "wr_unmapped_8050");
    bus_wr(32'h0000_8110, 32'd1,         1'b1, "wr_unmapped_msip4");
    bus_wr(32'h0000_802C, 32'd0,         1'b1, "wr_unmapped_cmp4");
    bus_wr(32'h0000_8200, 32'd1,         1'b1, "wr_unmapped_8200");
    bus_rd(A_PRESC,   32'd0, 32'd0, 1'b0, "post_unmapped_presc");
    bus_rd(msip_a(0), 32'd0, 32'd0, 1'b0, "post_unmapped_msip0");
    bus_rd(msip_a(2), 32'd1, 32'd1, 1'b0, "post_unmapped_msip2");
    bus_rd(msip_a(3), 32'd0, 32'd0, 1'b0, "post_unmapped_msip3");
    bus_rd(cmp_lo(3), 32'd0, 32'd0, 1'b0, "post_unmapped_cmp3");
    bus_rd(cmp_lo(1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "post_unmapped_cmp1");
    idle(2);
    check("post_unmapped_sirq", 32'(soft_irq),  32'b0100);
    check("post_unmapped_tirq", 32'(timer_irq), 32'b1000);

    // Reset while a read is in flight: its response must never appear.
    @(negedge clk);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = A_PRESC;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    bus_req = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(bus_ready), 32'd0);
    check("mid_rst_err",   32'(bus_err),   32'd0);
    check("mid_rst_rdata", bus_rdata,      32'd0);
    check("mid_rst_tirq",  32'(timer_irq), 32'd0);
    check("mid_rst_sirq",  32'(soft_irq),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Op k after release is sampled on edge k+1 and sees mtime = k.
    bus_rd(A_PRESC,           32'd0, 32'd0, 1'b0, "after_rst_presc");
    bus_rd(msip_a(2),         32'd0, 32'd0, 1'b0, "after_rst_msip2");
    bus_rd(cmp_lo(3) + 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "after_rst_cmp3_hi");
    bus_rd(A_MT_LO,           32'd4, 32'd4, 1'b0, "after_rst_mtime_lo");
    bus_rd(A_MT_HI,           32'd0, 32'd0, 1'b0, "after_rst_mtime_hi");
    idle(3);
    check("after_rst_tirq", 32'(timer_irq), 32'd0);
    check("after_rst_sirq", 32'(soft_irq),  32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
